buzzer_event_decoder: RTL and testbench

//  Receive side of the 3-line one-hot alarm buzzer interface driven by the sensor alarm block.

---
 rtl/buzzer_event_decoder_pkg.sv | 39 +++
 rtl/buzzer_event_decoder_evt_fifo.sv | 55 +++++
 rtl/buzzer_event_decoder.sv | 156 +++++++++++++++
 tb/tb_buzzer_event_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_event_decoder_pkg.sv
// Shared definitions for the alarm buzzer interface: FSM states, zone and error codes,
// and the one-hot line to zone decode also used by the sensor alarm block.
package buzzer_event_decoder_pkg;

    localparam int BUZ_W  = 3;
    localparam int ZONE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_ABORT   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ZONE_NONE = 2'd0,
        ZONE_1    = 2'd1,
        ZONE_2    = 2'd2,
        ZONE_3    = 2'd3
    } zone_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MULTI = 2'd1,
        ERR_LEN   = 2'd2
    } err_t;

    // Anything other than exactly one active line decodes to ZONE_NONE.
    function automatic zone_t onehot_to_zone(input logic [BUZ_W-1:0] lines);
        zone_t zone;
        case (lines)
            3'b001:  zone = ZONE_1;
            3'b010:  zone = ZONE_2;
            3'b100:  zone = ZONE_3;
            default: zone = ZONE_NONE;
        endcase
        return zone;
    endfunction

endpackage

// File: rtl/buzzer_event_decoder_evt_fifo.sv
// Synchronous event FIFO; a push while full only succeeds if a pop happens on the same edge.
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      cnt_r;
    logic             wr_s;
    logic             rd_s;

    assign full  = (cnt_r == (AW+1)'(DEPTH));
    assign empty = (cnt_r == (AW+1)'(0));
    assign wr_s  = push && (!full || pop);
    assign rd_s  = pop && !empty;
    assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/buzzer_event_decoder.sv
// Receive side of the one-hot alarm buzzer lines: validates and measures each pulse,
// queues {zone,len} events for the consumer and flags malformed pulses.
module buzzer_event_decoder
    import buzzer_event_decoder_pkg::*;
#(
    parameter int MIN_LEN = 28,
    parameter int MAX_LEN = 34,
    parameter int LEN_W   = 6,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       buz,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_zone,
    output logic [LEN_W-1:0] evt_len,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [7:0]       drop_cnt
);
    localparam int ENTRY_W = ZONE_W + LEN_W;
    localparam logic [LEN_W-1:0] LEN_SAT = {LEN_W{1'b1}};

    state_t             state_r, state_n_s;
    zone_t              zone_r, zone_n_s, zone_in_s;
    err_t               err_code_r, err_code_s;
    logic [LEN_W-1:0]   len_r, len_n_s;
    logic               first_r;
    logic               push_s;
    logic               err_s;
    logic               err_pulse_r;
    logic [7:0]         drop_cnt_r;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_pop_s;
    logic [ENTRY_W-1:0] fifo_din_s;
    logic [ENTRY_W-1:0] fifo_dout_s;

    assign zone_in_s  = onehot_to_zone(buz);
    assign fifo_din_s = {zone_r, len_r};
    assign fifo_pop_s = evt_ready && !fifo_empty_s;

    // Next-state, length counting and error detection on the sampled buzzer lines.
    always_comb begin
        state_n_s  = state_r;
        zone_n_s   = zone_r;
        len_n_s    = len_r;
        push_s     = 1'b0;
        err_s      = 1'b0;
        err_code_s = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (buz == 3'b000) begin
                    state_n_s = ST_IDLE;
                end else if (first_r) begin
                    // Lines already active out of reset: a pulse we never saw start.
                    state_n_s = ST_ABORT;
                end else if (zone_in_s != ZONE_NONE) begin
                    state_n_s = ST_MEASURE;
                    zone_n_s  = zone_in_s;
                    len_n_s   = LEN_W'(1);
                end else begin
                    state_n_s  = ST_ABORT;
                    err_s      = 1'b1;
                    err_code_s = ERR_MULTI;
                end
            end
            ST_MEASURE: begin
                if (buz == 3'b000) begin
                    state_n_s = ST_IDLE;
                    if ((len_r >= LEN_W'(MIN_LEN)) && (len_r <= LEN_W'(MAX_LEN))) begin
                        push_s = 1'b1;
                    end else begin
                        err_s      = 1'b1;
                        err_code_s = ERR_LEN;
                    end
                end else if (zone_in_s == zone_r) begin
                    if (len_r != LEN_SAT) begin
                        len_n_s = len_r + LEN_W'(1);
                    end else begin
                        len_n_s = len_r;
                    end
                end else begin
                    state_n_s  = ST_ABORT;
                    err_s      = 1'b1;
                    err_code_s = ERR_MULTI;
                end
            end
            ST_ABORT: begin
                if (buz == 3'b000) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_ABORT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // FSM, pulse measurement and post-reset guard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            zone_r  <= ZONE_NONE;
            len_r   <= {LEN_W{1'b0}};
            first_r <= 1'b1;
        end else begin
            state_r <= state_n_s;
            zone_r  <= zone_n_s;
            len_r   <= len_n_s;
            first_r <= 1'b0;
        end
    end

    // Error strobe with a sticky code, and saturating count of events lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            drop_cnt_r  <= 8'd0;
        end else begin
            err_pulse_r <= err_s;
            if (err_s) begin
                err_code_r <= err_code_s;
            end
            if (push_s && fifo_full_s && !fifo_pop_s && (drop_cnt_r != 8'd255)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_evt_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (fifo_pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign evt_valid = !fifo_empty_s;
    assign evt_zone  = fifo_dout_s[ENTRY_W-1 -: ZONE_W];
    assign evt_len   = fifo_dout_s[LEN_W-1:0];
    assign err_pulse = err_pulse_r;
    assign err_code  = err_code_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_buzzer_event_decoder.sv
// Directed bench for buzzer_event_decoder: expected events go into a scoreboard queue
// as pulses are driven and are checked when the consumer takes them.
module tb_buzzer_event_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] buz;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_zone;
    logic [5:0] evt_len;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         err_seen = 0;
    int         exp_err  = 0;
    logic       prev_err = 1'b0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    buzzer_event_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buz       (buz),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_zone  (evt_zone),
        .evt_len   (evt_len),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] zone_of(input logic [2:0] b);
        case (b)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Observes outputs mid-cycle: counts error strobes and scores consumed events.
    task automatic monitor();
        logic [7:0] exp_evt;
        if (err_pulse === 1'b1) begin
            err_seen++;
            check("err_one_cycle", 32'(prev_err), 32'd0);
        end
        prev_err = err_pulse;
        if (rst_n && evt_valid && evt_ready) begin
            check("evt_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_evt = sb.pop_front();
                check("evt_zone", 32'(evt_zone), 32'(exp_evt[7:6]));
                check("evt_len", 32'(evt_len), 32'(exp_evt[5:0]));
            end
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are looked at on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
        end
        #2;
    endtask

    task automatic pulse(input logic [2:0] bits, input int n, input bit dropped);
        if (n >= 28 && n <= 34) begin
            if (!dropped) sb.push_back({zone_of(bits), 6'(n)});
        end else begin
            exp_err++;
        end
        buz = bits;
        tick(n);
        buz = 3'b000;
        tick(2);
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() != 0) tick(1);
        end
        tick(2);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        buz       = 3'b000;
        evt_ready = 1'b1;
        tick(3);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_zone", 32'(evt_zone), 32'd0);
        check("rst_len", 32'(evt_len), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Nominal pulse
        pulse(3'b001, 31, 1'b0);
        check("t1_err", 32'(err_seen), 32'(exp_err));
        check("t1_queue", 32'(sb.size()), 32'd0);

        // Too short, too long
        pulse(3'b100, 10, 1'b0);
        check("t2_short_err", 32'(err_seen), 32'(exp_err));
        check("t2_short_code", 32'(err_code), 32'd2);
        pulse(3'b100, 40, 1'b0);
        check("t2_long_err", 32'(err_seen), 32'(exp_err));
        check("t2_long_code", 32'(err_code), 32'd2);

        // Zone change mid-pulse, stays aborted, then a normal pulse
        buz = 3'b010;
        tick(5);
        buz = 3'b011;
        exp_err++;
        tick(3);
        check("t3_change_err", 32'(err_seen), 32'(exp_err));
        check("t3_change_code", 32'(err_code), 32'd1);
        buz = 3'b010;
        tick(4);
        buz = 3'b000;
        tick(2);
        check("t3_no_second_err", 32'(err_seen), 32'(exp_err));
        pulse(3'b001, 31, 1'b0);
        check("t3_code_held", 32'(err_code), 32'd1);

        // Multi-hot from idle
        buz = 3'b110;
        exp_err++;
        tick(3);
        buz = 3'b000;
        tick(2);
        check("idle_multi_err", 32'(err_seen), 32'(exp_err));
        check("idle_multi_code", 32'(err_code), 32'd1);

        // Length boundaries
        pulse(3'b010, 28, 1'b0);
        pulse(3'b100, 34, 1'b0);
        pulse(3'b001, 27, 1'b0);
        check("b27_code", 32'(err_code), 32'd2);
        pulse(3'b010, 35, 1'b0);
        check("bnd_err", 32'(err_seen), 32'(exp_err));
        check("bnd_queue", 32'(sb.size()), 32'd0);

        // Fill the FIFO and overflow by one
        evt_ready = 1'b0;
        pulse(3'b001, 31, 1'b0);
        pulse(3'b010, 30, 1'b0);
        pulse(3'b100, 29, 1'b0);
        pulse(3'b001, 33, 1'b0);
        pulse(3'b010, 31, 1'b1);
        check("t4_drop", 32'(drop_cnt), 32'd1);
        check("t4_valid", 32'(evt_valid), 32'd1);
        check("t4_head_zone", 32'(evt_zone), 32'd1);

        // Full FIFO: push coincides with a pop
        sb.push_back({2'd3, 6'd32});
        buz = 3'b100;
        tick(32);
        buz       = 3'b000;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(2);
        check("t5_drop_same", 32'(drop_cnt), 32'd1);
        check("t5_head_zone", 32'(evt_zone), 32'd2);
        check("t5_head_len", 32'(evt_len), 32'd30);
        drain();

        // Reset mid-pulse, released while buz is still high
        buz = 3'b001;
        tick(15);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        buz = 3'b000;
        tick(2);
        check("t6_err", 32'(err_seen), 32'(exp_err));
        check("t6_valid", 32'(evt_valid), 32'd0);
        check("t6_code", 32'(err_code), 32'd0);
        check("t6_drop", 32'(drop_cnt), 32'd0);
        evt_ready = 1'b1;
        pulse(3'b010, 30, 1'b0);
        drain();
        check("final_err", 32'(err_seen), 32'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
